// File: rtl/uart_led_cmd_parser.sv
// Frames received UART bytes into 4-byte SYNC/CMD/DATA/CHK packets and applies valid
// commands to a registered LED byte, reporting aborted frames via pulse, code and counter.
module uart_led_cmd_parser #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1200000,
  parameter logic [7:0]  LED_RESET      = 8'h00
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_error,
  output logic [7:0] led,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GET_CMD  = 2'd1,
    GET_DATA = 2'd2,
    GET_CHK  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_CHECKSUM = 2'd1,
    ERR_UNKNOWN  = 2'd2,
    ERR_LINK     = 2'd3
  } err_t;

  localparam logic [23:0] TIMER_LAST = 24'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [23:0] timer;
  logic [7:0]  cmd_q;
  logic [7:0]  data_q;

  logic [7:0]  chk_expected;
  logic        cmd_known;
  logic        timeout;
  logic        err_fire;
  err_t        err_val;

  function automatic logic [7:0] apply_cmd(input logic [7:0] cmd,
                                           input logic [7:0] cur,
                                           input logic [7:0] d);
    case (cmd)
      8'h01:   return d;
      8'h02:   return cur | d;
      8'h03:   return cur & ~d;
      8'h04:   return cur ^ d;
      default: return cur;
    endcase
  endfunction

  assign chk_expected = cmd_q + data_q;
  assign cmd_known    = (cmd_q inside {8'h01, 8'h02, 8'h03, 8'h04});
  // A byte arriving on the expiry cycle wins over the timeout.
  assign timeout      = (state != IDLE) && !rx_valid && (timer == TIMER_LAST);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    err_fire = 1'b0;
    err_val  = ERR_NONE;
    if (state != IDLE && (rx_error || timeout)) begin
      err_fire = 1'b1;
      err_val  = ERR_LINK;
    end else if (state == GET_CHK && rx_valid) begin
      if (rx_data != chk_expected) begin
        err_fire = 1'b1;
        err_val  = ERR_CHECKSUM;
      end else if (!cmd_known) begin
        err_fire = 1'b1;
        err_val  = ERR_UNKNOWN;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      timer     <= '0;
      cmd_q     <= '0;
      data_q    <= '0;
      led       <= LED_RESET;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= ERR_NONE;
      err_count <= '0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      if (err_fire) begin
        frame_err <= 1'b1;
        err_code  <= err_val;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        state     <= IDLE;
        timer     <= '0;
      end else begin
        case (state)
          IDLE: begin
            timer <= '0;
            if (rx_valid && !rx_error && rx_data == SYNC_BYTE) state <= GET_CMD;
          end
          GET_CMD: begin
            if (rx_valid) begin
              cmd_q <= rx_data;
              timer <= '0;
              state <= GET_DATA;
            end else begin
              timer <= timer + 24'd1;
            end
          end
          GET_DATA: begin
            if (rx_valid) begin
              data_q <= rx_data;
              timer  <= '0;
              state  <= GET_CHK;
            end else begin
              timer <= timer + 24'd1;
            end
          end
          GET_CHK: begin
            if (rx_valid) begin
              led      <= apply_cmd(cmd_q, led, data_q);
              frame_ok <= 1'b1;
              timer    <= '0;
              state    <= IDLE;
            end else begin
              timer <= timer + 24'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_led_cmd_parser.sv
// Randomised and directed bench for uart_led_cmd_parser against a byte-queue frame model.
module tb_uart_led_cmd_parser;

  localparam int         TO   = 100;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_error = 1'b0;
  logic [7:0] led;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic [7:0] err_count;

  uart_led_cmd_parser #(
    .SYNC_BYTE(SYNC),
    .TIMEOUT_CYCLES(TO),
    .LED_RESET(8'h00)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rx_error(rx_error),
    .led(led),
    .frame_ok(frame_ok),
    .frame_err(frame_err),
    .err_code(err_code),
    .err_count(err_count)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the bytes of the frame in progress, cycles since the last byte.
  logic [7:0] m_led;
  logic [1:0] m_code;
  int         m_count;
  logic [7:0] fq[$];
  int         gap;
  bit         m_ok_now, m_err_now;
  int         m_ok_total = 0, m_err_total = 0;
  int         ok_seen = 0, err_seen = 0, both_seen = 0, trace_bad = 0;

  function automatic void m_reset();
    m_led   = 8'h00;
    m_code  = 2'd0;
    m_count = 0;
    fq.delete();
    gap     = 0;
  endfunction

  function automatic void m_abort(input logic [1:0] c);
    m_code = c;
    if (m_count < 255) m_count++;
    fq.delete();
    gap = 0;
    m_err_now = 1'b1;
  endfunction

  function automatic void m_finish_frame();
    logic [7:0] s;
    s = fq[1] + fq[2];
    if (fq[3] != s) m_abort(2'd1);
    else begin
      case (fq[1])
        8'h01: begin m_led = fq[2];          m_ok_now = 1'b1; end
        8'h02: begin m_led = m_led | fq[2];  m_ok_now = 1'b1; end
        8'h03: begin m_led = m_led & ~fq[2]; m_ok_now = 1'b1; end
        8'h04: begin m_led = m_led ^ fq[2];  m_ok_now = 1'b1; end
        default: m_abort(2'd2);
      endcase
      fq.delete();
    end
  endfunction

  function automatic void m_cycle(input bit v, input logic [7:0] d, input bit e);
    m_ok_now  = 1'b0;
    m_err_now = 1'b0;
    if (fq.size() == 0) begin
      if (v && !e && d == SYNC) begin
        fq.push_back(d);
        gap = 0;
      end
    end else if (e) begin
      m_abort(2'd3);
    end else if (v) begin
      fq.push_back(d);
      gap = 0;
      if (fq.size() == 4) m_finish_frame();
    end else begin
      gap++;
      if (gap == TO) m_abort(2'd3);
    end
  endfunction

  task automatic step(input bit v, input logic [7:0] d, input bit e);
    @(negedge CLK);
    rx_valid = v;
    rx_data  = d;
    rx_error = e;
    @(posedge CLK);
    m_cycle(v, d, e);
    #1;
    rx_valid = 1'b0;
    rx_error = 1'b0;
    if (frame_ok) ok_seen++;
    if (frame_err) err_seen++;
    if (frame_ok && frame_err) both_seen++;
    if (m_ok_now) m_ok_total++;
    if (m_err_now) m_err_total++;
    if (led !== m_led || err_code !== m_code || err_count !== 8'(m_count) ||
        frame_ok !== m_ok_now || frame_err !== m_err_now) trace_bad++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] d, input logic [7:0] k);
    step(1'b1, SYNC, 1'b0);
    step(1'b1, c, 1'b0);
    step(1'b1, d, 1'b0);
    step(1'b1, k, 1'b0);
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (led !== 8'h00 || frame_ok !== 1'b0 || frame_err !== 1'b0 ||
        err_code !== 2'd0 || err_count !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_state: led=%h ok=%b err=%b code=%0d count=%0d, want 00 0 0 0 0",
               led, frame_ok, frame_err, err_code, err_count);
    end
    m_reset();
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_set();
    int ok0;
    ok0 = ok_seen;
    step(1'b1, SYNC, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h3C, 1'b0);
    step(1'b1, 8'h3D, 1'b0);
    n_cmp++;
    if (frame_ok !== 1'b1 || led !== 8'h3C) begin
      n_bad++;
      $display("FAIL set_latency: ok=%b led=%h, want 1 3c", frame_ok, led);
    end
    idle(2);
    n_cmp++;
    if (ok_seen - ok0 != 1 || frame_ok !== 1'b0) begin
      n_bad++;
      $display("FAIL set_pulse: pulses=%0d ok=%b, want 1 0", ok_seen - ok0, frame_ok);
    end
    n_cmp++;
    if (err_code !== 2'd0 || err_count !== 8'd0) begin
      n_bad++;
      $display("FAIL set_errs: code=%0d count=%0d, want 0 0", err_code, err_count);
    end
  endtask

  task automatic test_ops();
    int ok0;
    ok0 = ok_seen;
    send_frame(8'h02, 8'hC0, 8'hC2);
    n_cmp++;
    if (led !== 8'hFC) begin n_bad++; $display("FAIL op_or: led=%h want fc", led); end
    send_frame(8'h03, 8'h0C, 8'h0F);
    n_cmp++;
    if (led !== 8'hF0) begin n_bad++; $display("FAIL op_andn: led=%h want f0", led); end
    send_frame(8'h04, 8'hFF, 8'h03);
    n_cmp++;
    if (led !== 8'h0F) begin n_bad++; $display("FAIL op_xor: led=%h want 0f", led); end
    idle(1);
    n_cmp++;
    if (ok_seen - ok0 != 3) begin
      n_bad++;
      $display("FAIL op_pulses: got %0d want 3", ok_seen - ok0);
    end
  endtask

  task automatic test_errors();
    send_frame(8'h01, 8'h55, 8'h00);
    n_cmp++;
    if (frame_err !== 1'b1 || err_code !== 2'd1 || err_count !== 8'd1 || led !== 8'h0F) begin
      n_bad++;
      $display("FAIL err_checksum: err=%b code=%0d count=%0d led=%h, want 1 1 1 0f",
               frame_err, err_code, err_count, led);
    end
    send_frame(8'h07, 8'h01, 8'h08);
    n_cmp++;
    if (frame_err !== 1'b1 || err_code !== 2'd2 || err_count !== 8'd2 || led !== 8'h0F) begin
      n_bad++;
      $display("FAIL err_unknown: err=%b code=%0d count=%0d led=%h, want 1 2 2 0f",
               frame_err, err_code, err_count, led);
    end
    send_frame(8'h01, 8'h0F, 8'h10);
    n_cmp++;
    if (err_code !== 2'd2 || led !== 8'h0F) begin
      n_bad++;
      $display("FAIL err_code_held: code=%0d led=%h, want 2 0f", err_code, led);
    end
  endtask

  task automatic test_timeout();
    int e0;
    step(1'b1, SYNC, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    e0 = err_seen;
    idle(TO - 1);
    n_cmp++;
    if (err_seen != e0) begin
      n_bad++;
      $display("FAIL timeout_early: errors=%0d want 0", err_seen - e0);
    end
    // The expiry cycle is the TO-th consecutive cycle without a byte.
    idle(1);
    n_cmp++;
    if (frame_err !== 1'b1 || err_code !== 2'd3 || err_count !== 8'd3) begin
      n_bad++;
      $display("FAIL timeout_fire: err=%b code=%0d count=%0d, want 1 3 3",
               frame_err, err_code, err_count);
    end
    e0 = err_seen;
    step(1'b1, SYNC, 1'b0);
    idle(TO - 1);
    step(1'b1, 8'h01, 1'b0);
    idle(TO - 1);
    step(1'b1, 8'hAA, 1'b0);
    idle(TO - 1);
    step(1'b1, 8'hAB, 1'b0);
    n_cmp++;
    if (led !== 8'hAA || frame_ok !== 1'b1 || err_seen != e0) begin
      n_bad++;
      $display("FAIL timeout_boundary: led=%h ok=%b errors=%0d, want aa 1 0",
               led, frame_ok, err_seen - e0);
    end
  endtask

  task automatic test_junk_rx_error();
    int e0, ok0;
    e0 = err_seen;
    ok0 = ok_seen;
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, SYNC, 1'b1);
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h3C, 1'b0);
    step(1'b1, 8'h3D, 1'b0);
    idle(1);
    n_cmp++;
    if (err_seen != e0 || ok_seen != ok0 || err_count !== 8'd3 || led !== 8'hAA) begin
      n_bad++;
      $display("FAIL idle_ignore: errors=%0d oks=%0d count=%0d led=%h, want 0 0 3 aa",
               err_seen - e0, ok_seen - ok0, err_count, led);
    end
    step(1'b1, SYNC, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    n_cmp++;
    if (frame_err !== 1'b1 || err_code !== 2'd3 || err_count !== 8'd4) begin
      n_bad++;
      $display("FAIL rx_error_abort: err=%b code=%0d count=%0d, want 1 3 4",
               frame_err, err_code, err_count);
    end
    step(1'b1, SYNC, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h3C, 1'b1);
    step(1'b1, 8'h3D, 1'b0);
    idle(1);
    n_cmp++;
    if (led !== 8'hAA || err_count !== 8'd5 || err_code !== 2'd3) begin
      n_bad++;
      $display("FAIL byte_and_error: led=%h count=%0d code=%0d, want aa 5 3",
               led, err_count, err_code);
    end
  endtask

  task automatic test_random();
    int ok0, e0, mok0, merr0;
    logic [7:0] b[4];
    ok0 = ok_seen; e0 = err_seen; mok0 = m_ok_total; merr0 = m_err_total;
    for (int f = 0; f < 40; f++) begin
      int kind;
      kind = $urandom_range(0, 9);
      b[0] = SYNC;
      b[1] = (kind < 7) ? 8'($urandom_range(1, 4)) : 8'($urandom);
      b[2] = 8'($urandom);
      b[3] = b[1] + b[2];
      if (kind == 9) b[3] = b[3] ^ 8'h01;
      if ($urandom_range(0, 4) == 0) step(1'b1, 8'($urandom), 1'b0);
      for (int i = 0; i < 4; i++) begin
        idle(($urandom_range(0, 39) == 0) ? TO : $urandom_range(0, 3));
        step(1'b1, b[i], $urandom_range(0, 29) == 0);
      end
    end
    idle(TO + 1);
    n_cmp++;
    if (ok_seen - ok0 != m_ok_total - mok0 || err_seen - e0 != m_err_total - merr0) begin
      n_bad++;
      $display("FAIL random_pulses: ok=%0d err=%0d, want ok=%0d err=%0d",
               ok_seen - ok0, err_seen - e0, m_ok_total - mok0, m_err_total - merr0);
    end
  endtask

  task automatic test_saturate_and_reset();
    int e0;
    send_frame(8'h01, 8'h5A, 8'h5B);
    for (int i = 0; i < 260; i++) send_frame(8'h01, 8'h55, 8'h00);
    n_cmp++;
    if (err_count !== 8'd255 || err_code !== 2'd1 || led !== 8'h5A) begin
      n_bad++;
      $display("FAIL saturate: count=%0d code=%0d led=%h, want 255 1 5a",
               err_count, err_code, led);
    end
    step(1'b1, SYNC, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    e0 = err_seen;
    @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    n_cmp++;
    if (led !== 8'h00 || frame_ok !== 1'b0 || frame_err !== 1'b0 ||
        err_code !== 2'd0 || err_count !== 8'd0) begin
      n_bad++;
      $display("FAIL async_reset: led=%h ok=%b err=%b code=%0d count=%0d, want 00 0 0 0 0",
               led, frame_ok, frame_err, err_code, err_count);
    end
    m_reset();
    @(posedge CLK);
    #1;
    if (frame_err) err_seen++;
    @(negedge CLK);
    RST_N = 1'b1;
    step(1'b1, 8'h5A, 1'b0);
    step(1'b1, 8'h5B, 1'b0);
    idle(TO + 2);
    n_cmp++;
    if (err_seen != e0 || err_count !== 8'd0 || led !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_discard: errors=%0d count=%0d led=%h, want 0 0 00",
               err_seen - e0, err_count, led);
    end
  endtask

  task automatic test_trace();
    n_cmp++;
    if (trace_bad != 0 || both_seen != 0) begin
      n_bad++;
      $display("FAIL cycle_trace: bad_cycles=%0d both_high=%0d, want 0 0", trace_bad, both_seen);
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_set();
    test_ops();
    test_errors();
    test_timeout();
    test_junk_rx_error();
    test_random();
    test_saturate_and_reset();
    test_trace();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_led_cmd_parser.md
Name: uart_led_cmd_parser

Overview:
Downstream consumer of the UART receiver's byte stream. It frames the received bytes into fixed 4-byte command packets, validates each packet, and applies the command to a registered 8-bit LED output. Bad or stalled packets are reported through pulses, a last-error code and a saturating error counter.

Parameters:
SYNC_BYTE, 8'hA5, first byte of every frame
TIMEOUT_CYCLES, 1200000, max CLK cycles allowed between bytes inside a frame (legal range 2 to 2^24-1)
LED_RESET, 8'h00, value of led after reset

Ports:
CLK  input  1  system clock; all logic on rising edge
RST_N  input  1  asynchronous, active-low reset
rx_valid  input  1  one-cycle strobe from receiver: rx_data holds a new byte
rx_data  input  8  received byte, valid only while rx_valid=1
rx_error  input  1  one-cycle strobe from receiver: framing/stop-bit error
led  output  8  registered LED state
frame_ok  output  1  one-cycle pulse: a frame was accepted and applied
frame_err  output  1  one-cycle pulse: a frame was aborted
err_code  output  2  last error: 0 none, 1 checksum, 2 unknown cmd, 3 timeout/rx_error
err_count  output  8  aborted-frame count, saturates at 255

Behaviour:
- Reset (RST_N=0, asynchronous): state=IDLE, led=LED_RESET, frame_ok=0, frame_err=0, err_code=0, err_count=0, timer=0, cmd/data regs=0.
- Frame: SYNC_BYTE, CMD, DATA, CHK. CHK must equal (CMD+DATA) mod 256.
- Commands: 8'h01 set led=DATA; 8'h02 led=led|DATA; 8'h03 led=led&~DATA; 8'h04 led=led^DATA. Any other value is an unknown cmd.
- FSM states: IDLE, GET_CMD, GET_DATA, GET_CHK.
  - IDLE: on rx_valid with rx_data==SYNC_BYTE go to GET_CMD. Other bytes and rx_error are ignored silently.
  - GET_CMD: on rx_valid latch cmd and go to GET_DATA. The cmd is not checked here.
  - GET_DATA: on rx_valid latch data and go to GET_CHK.
  - GET_CHK: on rx_valid compare the byte against cmd+data, then go to IDLE.
    - Checksum mismatch: error, code 1.
    - Checksum good but cmd unknown: error, code 2.
    - Checksum good and cmd known: apply the command.
- A SYNC_BYTE value received in GET_CMD, GET_DATA or GET_CHK is treated as ordinary data. There is no resync.
- Latency: led and frame_ok update on the CLK edge that samples rx_valid=1 for the CHK byte. Both are visible 1 cycle after that strobe cycle. frame_ok is high for exactly one cycle. frame_ok is asserted even if led does not change (e.g. OR with 0).
- Error action (all on one edge):
  - frame_err=1 for one cycle.
  - err_code is updated.
  - err_count increments unless it is already 255.
  - state returns to IDLE.
  - led is unchanged.
- err_code holds its value until the next error or reset. A successful frame does not clear it.
- Timer:
  - Cleared on entry to GET_CMD and on every rx_valid while outside IDLE.
  - Increments every cycle while outside IDLE.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_valid in that cycle: error, code 3.
  - Held at 0 in IDLE.
- rx_error while outside IDLE: error, code 3, same cycle behaviour as timeout.
- Simultaneous events:
  - rx_valid and rx_error in the same cycle outside IDLE: rx_error wins and the byte is discarded.
  - rx_valid in the same cycle the timer expires: the byte wins and the timer clears.
  - In IDLE with rx_valid=SYNC_BYTE and rx_error both high: the byte is ignored and the FSM stays in IDLE.
- frame_ok and frame_err are never high in the same cycle.
- Reset mid-frame: returns to IDLE immediately. The partial frame is discarded with no frame_err pulse.
- Inputs are synchronous to CLK (receiver is on the same clock). No input synchronisers.

Test Plan:
1. Reset, then send A5 01 3C 3D -> led=8'h3C one cycle after the CHK strobe; frame_ok one 1-cycle pulse; err_count=0; err_code=0.
2. From led=3C, send A5 02 C0 C2 then A5 03 0C 0F then A5 04 FF 03 -> led goes 3C -> FC -> F0 -> 0F; three frame_ok pulses.
3. Send A5 01 55 00 (bad checksum) -> frame_err pulse, err_code=1, err_count=1, led unchanged. Then send A5 07 01 08 -> err_code=2, err_count=2, led unchanged.
4. With TIMEOUT_CYCLES=100: send A5 01, then idle 99 cycles -> frame_err on the expiry cycle, err_code=3. A following A5 01 AA AB -> led=AA. Also check a byte arriving on cycle 99 exactly is accepted and no timeout fires.
5. Send 00 11 FF (junk in IDLE) -> no pulses, err_count unchanged. Then A5 01 with rx_error on the 3rd byte -> frame_err, err_code=3. Then a byte with rx_valid and rx_error asserted together mid-frame -> byte discarded.
6. Drive 260 bad-checksum frames -> err_count saturates at 255. Then assert RST_N=0 mid-frame -> all outputs return to reset values asynchronously, with no frame_err pulse.
